// File: rtl/jtag_pkg.sv
// Shared types and pin encodings for the Bus Blaster reset sequencer.
package jtag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } rst_state_e;

    // Buffer pins: both low = actively driving reset, both high = released.
    localparam logic PIN_DRIVE   = 1'b0;
    localparam logic PIN_RELEASE = 1'b1;

    function automatic logic is_drive_req(input logic oe_n, input logic out);
        return (oe_n == PIN_DRIVE) && (out == PIN_DRIVE);
    endfunction

    function automatic logic is_driving(input rst_state_e st);
        return (st == ST_ASSERT) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability counter; the level output
// only toggles after the synced pin has disagreed for DEBOUNCE_CYC cycles.
module sync_debounce #(
    parameter int DEBOUNCE_CYC = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o
);

    localparam int             CW   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYC - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= pin_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/jtag_reset_seq.sv
// Conditions FT2232 nSRST/nTRST requests into minimum-width, supervised
// reset pulses for the jtagkey buffer, gated by debounced target presence.
module jtag_reset_seq
    import jtag_pkg::*;
#(
    parameter int SRST_MIN_CYC = 1000,
    parameter int TRST_MIN_CYC = 100,
    parameter int REL_TMO_CYC  = 4000,
    parameter int DEBOUNCE_CYC = 256
) (
    input  logic CLK,
    input  logic nRST,
    input  logic FT_nSRST_OE,
    input  logic FT_nSRST_OUT,
    input  logic FT_nTRST_OE,
    input  logic FT_nTRST_OUT,
    input  logic nSRST_SENSE,
    input  logic TARGET_PRESENT,
    output logic SRST_OE_N,
    output logic SRST_OUT,
    output logic TRST_OE_N,
    output logic TRST_OUT,
    output logic TARGET_PRESENT_Q,
    output logic SRST_BUSY,
    output logic EXT_SRST,
    output logic SRST_STUCK
);

    localparam int SRST_CNT_MAX = (SRST_MIN_CYC > REL_TMO_CYC) ? SRST_MIN_CYC : REL_TMO_CYC;
    localparam int SCW          = $clog2(SRST_CNT_MAX + 1);
    localparam int TCW          = $clog2(TRST_MIN_CYC + 1);
    localparam logic [SCW-1:0] SRST_LAST = SCW'(SRST_MIN_CYC - 1);
    localparam logic [SCW-1:0] REL_LAST  = SCW'(REL_TMO_CYC - 1);
    localparam logic [TCW-1:0] TRST_LAST = TCW'(TRST_MIN_CYC - 1);

    logic [3:0]     pins_s1_q, pins_s2_q;
    logic           sense_s1_q, sense_s2_q, sense_prev_q;
    logic           present_q;
    logic           srst_req, trst_req;

    rst_state_e     srst_state_q, srst_state_d;
    rst_state_e     trst_state_q, trst_state_d;
    logic [SCW-1:0] srst_cnt_q, srst_cnt_d;
    logic [TCW-1:0] trst_cnt_q, trst_cnt_d;
    logic           stuck_q, stuck_d;
    logic           ext_q, ext_d;
    logic           srst_oe_n_q, srst_out_q, trst_oe_n_q, trst_out_q, busy_q;

    sync_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_presence (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .pin_i  (TARGET_PRESENT),
        .level_o(present_q)
    );

    // Sense syncs reset high so a released target never fakes an EXT_SRST.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pins_s1_q    <= '1;
            pins_s2_q    <= '1;
            sense_s1_q   <= 1'b1;
            sense_s2_q   <= 1'b1;
            sense_prev_q <= 1'b1;
        end else begin
            pins_s1_q    <= {FT_nSRST_OE, FT_nSRST_OUT, FT_nTRST_OE, FT_nTRST_OUT};
            pins_s2_q    <= pins_s1_q;
            sense_s1_q   <= nSRST_SENSE;
            sense_s2_q   <= sense_s1_q;
            sense_prev_q <= sense_s2_q;
        end
    end

    assign srst_req = is_drive_req(pins_s2_q[3], pins_s2_q[2]);
    assign trst_req = is_drive_req(pins_s2_q[1], pins_s2_q[0]);

    // A short request leaves ASSERT straight for RELEASE so the pulse is
    // exactly SRST_MIN_CYC wide rather than one cycle longer via HOLD.
    always_comb begin
        srst_state_d = srst_state_q;
        srst_cnt_d   = srst_cnt_q;
        stuck_d      = stuck_q;
        if (!present_q) begin
            srst_state_d = ST_IDLE;
            srst_cnt_d   = '0;
        end else begin
            case (srst_state_q)
                ST_IDLE: begin
                    srst_cnt_d = '0;
                    if (srst_req) begin
                        srst_state_d = ST_ASSERT;
                        stuck_d      = 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (srst_cnt_q == SRST_LAST) begin
                        srst_state_d = srst_req ? ST_HOLD : ST_RELEASE;
                        srst_cnt_d   = '0;
                    end else begin
                        srst_cnt_d = srst_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!srst_req) begin
                        srst_state_d = ST_RELEASE;
                        srst_cnt_d   = '0;
                    end
                end
                ST_RELEASE: begin
                    if (srst_req) begin
                        srst_state_d = ST_ASSERT;
                        srst_cnt_d   = '0;
                    end else if (sense_s2_q) begin
                        srst_state_d = ST_IDLE;
                        srst_cnt_d   = '0;
                    end else if (srst_cnt_q == REL_LAST) begin
                        srst_state_d = ST_IDLE;
                        srst_cnt_d   = '0;
                        stuck_d      = 1'b1;
                    end else begin
                        srst_cnt_d = srst_cnt_q + 1'b1;
                    end
                end
                default: begin
                    srst_state_d = ST_IDLE;
                    srst_cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        trst_state_d = trst_state_q;
        trst_cnt_d   = trst_cnt_q;
        if (!present_q) begin
            trst_state_d = ST_IDLE;
            trst_cnt_d   = '0;
        end else begin
            case (trst_state_q)
                ST_IDLE: begin
                    trst_cnt_d = '0;
                    if (trst_req) begin
                        trst_state_d = ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (trst_cnt_q == TRST_LAST) begin
                        trst_state_d = trst_req ? ST_HOLD : ST_IDLE;
                        trst_cnt_d   = '0;
                    end else begin
                        trst_cnt_d = trst_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!trst_req) begin
                        trst_state_d = ST_IDLE;
                    end
                end
                default: begin
                    trst_state_d = ST_IDLE;
                    trst_cnt_d   = '0;
                end
            endcase
        end
    end

    assign ext_d = sense_prev_q & ~sense_s2_q & (srst_state_q == ST_IDLE);

    // Output flops load from next state so pins move on the same edge as the FSM.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            srst_state_q <= ST_IDLE;
            trst_state_q <= ST_IDLE;
            srst_cnt_q   <= '0;
            trst_cnt_q   <= '0;
            stuck_q      <= 1'b0;
            ext_q        <= 1'b0;
            busy_q       <= 1'b0;
            srst_oe_n_q  <= PIN_RELEASE;
            srst_out_q   <= PIN_RELEASE;
            trst_oe_n_q  <= PIN_RELEASE;
            trst_out_q   <= PIN_RELEASE;
        end else begin
            srst_state_q <= srst_state_d;
            trst_state_q <= trst_state_d;
            srst_cnt_q   <= srst_cnt_d;
            trst_cnt_q   <= trst_cnt_d;
            stuck_q      <= stuck_d;
            ext_q        <= ext_d;
            busy_q       <= (srst_state_d != ST_IDLE);
            srst_oe_n_q  <= is_driving(srst_state_d) ? PIN_DRIVE : PIN_RELEASE;
            srst_out_q   <= is_driving(srst_state_d) ? PIN_DRIVE : PIN_RELEASE;
            trst_oe_n_q  <= is_driving(trst_state_d) ? PIN_DRIVE : PIN_RELEASE;
            trst_out_q   <= is_driving(trst_state_d) ? PIN_DRIVE : PIN_RELEASE;
        end
    end

    assign SRST_OE_N        = srst_oe_n_q;
    assign SRST_OUT         = srst_out_q;
    assign TRST_OE_N        = trst_oe_n_q;
    assign TRST_OUT         = trst_out_q;
    assign TARGET_PRESENT_Q = present_q;
    assign SRST_BUSY        = busy_q;
    assign EXT_SRST         = ext_q;
    assign SRST_STUCK       = stuck_q;

endmodule

// File: tb/tb_jtag_reset_seq.sv
// Scoreboard bench: stimulus queues every expected output change with the
// exact clock edge it should appear on; a monitor matches changes in order.
module tb_jtag_reset_seq;

    logic CLK = 1'b0;
    logic nRST;
    logic FT_nSRST_OE, FT_nSRST_OUT, FT_nTRST_OE, FT_nTRST_OUT;
    logic nSRST_SENSE, TARGET_PRESENT;
    logic SRST_OE_N, SRST_OUT, TRST_OE_N, TRST_OUT;
    logic TARGET_PRESENT_Q, SRST_BUSY, EXT_SRST, SRST_STUCK;

    jtag_reset_seq #(
        .SRST_MIN_CYC(1000),
        .TRST_MIN_CYC(100),
        .REL_TMO_CYC (4000),
        .DEBOUNCE_CYC(256)
    ) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .FT_nSRST_OE     (FT_nSRST_OE),
        .FT_nSRST_OUT    (FT_nSRST_OUT),
        .FT_nTRST_OE     (FT_nTRST_OE),
        .FT_nTRST_OUT    (FT_nTRST_OUT),
        .nSRST_SENSE     (nSRST_SENSE),
        .TARGET_PRESENT  (TARGET_PRESENT),
        .SRST_OE_N       (SRST_OE_N),
        .SRST_OUT        (SRST_OUT),
        .TRST_OE_N       (TRST_OE_N),
        .TRST_OUT        (TRST_OUT),
        .TARGET_PRESENT_Q(TARGET_PRESENT_Q),
        .SRST_BUSY       (SRST_BUSY),
        .EXT_SRST        (EXT_SRST),
        .SRST_STUCK      (SRST_STUCK)
    );

    always #5 CLK = ~CLK;

    // Vector bits: 7 SRST_OE_N, 6 SRST_OUT, 5 TRST_OE_N, 4 TRST_OUT,
    // 3 TARGET_PRESENT_Q, 2 SRST_BUSY, 1 EXT_SRST, 0 SRST_STUCK.
    localparam logic [7:0] RESET_VEC = 8'b1111_0000;

    typedef struct {
        int         at_cyc;
        logic [7:0] v;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_v;
    logic [7:0] vec;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    assign vec = {SRST_OE_N, SRST_OUT, TRST_OE_N, TRST_OUT,
                  TARGET_PRESENT_Q, SRST_BUSY, EXT_SRST, SRST_STUCK};

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every change of the output vector is one transaction.
    logic [7:0] prev_v;
    bit         first = 1'b1;
    exp_t       got_e;
    always @(negedge CLK) begin
        if (first) begin
            first = 1'b0;
            tests++;
            if (vec !== RESET_VEC) begin
                fails++;
                $display("FAIL reset_state: got %b, want %b", vec, RESET_VEC);
            end else begin
                $display("[TB] cyc %0d reset_state %b ok", cyc, vec);
            end
            prev_v = vec;
        end else if (vec !== prev_v) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change: got %b at cyc %0d, want no change", vec, cyc);
            end else begin
                got_e = exp_q.pop_front();
                if (vec !== got_e.v || cyc != got_e.at_cyc) begin
                    fails++;
                    $display("FAIL output_change: got %b at cyc %0d, want %b at cyc %0d",
                             vec, cyc, got_e.v, got_e.at_cyc);
                end else begin
                    $display("[TB] cyc %0d outputs %b ok", cyc, vec);
                end
            end
            prev_v = vec;
        end else if (exp_q.size() != 0 && cyc > exp_q[0].at_cyc) begin
            tests++;
            fails++;
            got_e = exp_q.pop_front();
            $display("FAIL missing_change: got %b at cyc %0d, want %b at cyc %0d",
                     vec, cyc, got_e.v, got_e.at_cyc);
        end
    end

    task automatic push(input int c);
        exp_q.push_back('{at_cyc: c, v: exp_v});
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic srst_pin(input logic req);
        FT_nSRST_OE  = ~req;
        FT_nSRST_OUT = ~req;
    endtask

    task automatic trst_pin(input logic req);
        FT_nTRST_OE  = ~req;
        FT_nTRST_OUT = ~req;
    endtask

    task automatic exp_srst(input logic drive);
        exp_v[7] = ~drive;
        exp_v[6] = ~drive;
    endtask

    task automatic exp_trst(input logic drive);
        exp_v[5] = ~drive;
        exp_v[4] = ~drive;
    endtask

    int n, m, p;

    initial begin
        nRST = 1'b0;
        srst_pin(1'b0);
        trst_pin(1'b0);
        nSRST_SENSE    = 1'b1;
        TARGET_PRESENT = 1'b0;
        exp_v          = RESET_VEC;

        // Presence debounce: Q rises 258 edges after the pin.
        step_to(3);
        nRST = 1'b1;
        n = cyc;
        TARGET_PRESENT = 1'b1;
        exp_v[3] = 1'b1; push(n + 258);
        step_to(n + 300);

        // 10-cycle SRST and 5-cycle TRST: both stretched to their minimum.
        n = cyc;
        srst_pin(1'b1);
        trst_pin(1'b1);
        exp_srst(1'b1); exp_trst(1'b1); exp_v[2] = 1'b1; push(n + 3);
        exp_trst(1'b0); push(n + 103);
        exp_srst(1'b0); push(n + 1003);
        exp_v[2] = 1'b0; push(n + 1004);
        step_to(n + 5);
        trst_pin(1'b0);
        step_to(n + 10);
        srst_pin(1'b0);
        step_to(n + 1020);

        // 2000-cycle SRST with sense stuck low, 150-cycle TRST.
        n = cyc;
        srst_pin(1'b1);
        trst_pin(1'b1);
        exp_srst(1'b1); exp_trst(1'b1); exp_v[2] = 1'b1; push(n + 3);
        exp_trst(1'b0); push(n + 153);
        exp_srst(1'b0); push(n + 2003);
        exp_v[2] = 1'b0; exp_v[0] = 1'b1; push(n + 6003);
        step_to(n + 5);
        nSRST_SENSE = 1'b0;
        step_to(n + 150);
        trst_pin(1'b0);
        step_to(n + 2000);
        srst_pin(1'b0);
        step_to(n + 6010);

        // Next request clears STUCK; a second request lands during RELEASE.
        n = cyc;
        srst_pin(1'b1);
        exp_srst(1'b1); exp_v[2] = 1'b1; exp_v[0] = 1'b0; push(n + 3);
        exp_srst(1'b0); push(n + 1003);
        step_to(n + 10);
        srst_pin(1'b0);
        step_to(n + 1010);
        m = cyc;
        srst_pin(1'b1);
        exp_srst(1'b1); push(m + 3);
        exp_srst(1'b0); push(m + 1003);
        step_to(m + 10);
        srst_pin(1'b0);
        step_to(m + 1010);
        nSRST_SENSE = 1'b1;
        exp_v[2] = 1'b0; push(m + 1013);
        step_to(m + 1020);

        // Presence drops while both FSMs hold; later requests are ignored.
        n = cyc;
        srst_pin(1'b1);
        trst_pin(1'b1);
        exp_srst(1'b1); exp_trst(1'b1); exp_v[2] = 1'b1; push(n + 3);
        step_to(n + 1100);
        p = cyc;
        TARGET_PRESENT = 1'b0;
        exp_v[3] = 1'b0; push(p + 258);
        exp_srst(1'b0); exp_trst(1'b0); exp_v[2] = 1'b0; push(p + 259);
        step_to(p + 400);
        srst_pin(1'b0);
        trst_pin(1'b0);
        step_to(p + 420);
        srst_pin(1'b1);
        step_to(p + 440);
        srst_pin(1'b0);
        step_to(p + 460);

        // Target pulls nSRST itself while idle.
        n = cyc;
        nSRST_SENSE = 1'b0;
        exp_v[1] = 1'b1; push(n + 3);
        exp_v[1] = 1'b0; push(n + 4);
        step_to(n + 20);
        nSRST_SENSE = 1'b1;
        step_to(n + 30);

        // Asynchronous reset in the middle of a pulse.
        n = cyc;
        TARGET_PRESENT = 1'b1;
        exp_v[3] = 1'b1; push(n + 258);
        step_to(n + 300);
        m = cyc;
        srst_pin(1'b1);
        exp_srst(1'b1); exp_v[2] = 1'b1; push(m + 3);
        step_to(m + 50);
        exp_v = RESET_VEC; push(cyc);
        nRST = 1'b0;
        step_to(m + 55);
        srst_pin(1'b0);
        TARGET_PRESENT = 1'b0;
        nRST = 1'b1;
        step_to(m + 80);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: got %0d left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
